// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX-stage redirects, data-memory
// freezes with a deferred redirect, a memory watchdog and saturating perf counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             MUXsel_Hazard,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int BW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0]    TO_V    = BW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RUN, FREEZE, FREEZE_RD} state_t;

    state_t           state_q, state_d;
    logic             redir_pend_q, redir_pend_d;
    logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall_inc, flush_inc;

    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    // Next-state and pipeline controls; priority mem_busy > redirect > load-use.
    always_comb begin
        state_d       = RUN;
        redir_pend_d  = 1'b0;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        MUXsel_Hazard = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (mem_busy) begin
            // Full hold, no bubble; remember any redirect seen during the freeze.
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            stall_inc    = 1'b1;
            redir_pend_d = ex_redirect | redir_pend_q;
            state_d      = redir_pend_d ? FREEZE_RD : FREEZE;
        end else if (state_q == FREEZE_RD || ex_redirect) begin
            // Pending redirect is applied once; a still-high ex_redirect is the same event.
            MUXsel_Hazard = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            flush_inc     = 1'b1;
        end else if (load_use) begin
            PCWrite       = 1'b0;
            IFIDWrite     = 1'b0;
            MUXsel_Hazard = 1'b1;
            stall_inc     = 1'b1;
        end
        if (rst) begin
            PCWrite       = 1'b0;
            IFIDWrite     = 1'b0;
            MUXsel_Hazard = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end
    end

    // Watchdog and saturating counters.
    always_comb begin
        busy_cnt_d    = '0;
        if (mem_busy)
            busy_cnt_d = (busy_cnt_q == TO_V) ? TO_V : busy_cnt_q + 1'b1;
        mem_timeout_d = mem_timeout_q | (busy_cnt_d == TO_V);
        stall_cnt_d   = (stall_inc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d   = (flush_inc && flush_cnt_q != CNT_MAX) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    // State register with synchronous reset; reset drops any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            redir_pend_q  <= 1'b0;
            busy_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            redir_pend_q  <= redir_pend_d;
            busy_cnt_q    <= busy_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
endmodule
